// File: rtl/dc1_fill_pkg.sv
// Shared dcache fill definitions: geometry, line type, fill FSM states and request payload.
package dc1_fill_pkg;

    localparam int unsigned NPHYS      = 55;
    localparam int unsigned BEAT_W     = 128;
    localparam int unsigned LINE_W     = 512;
    localparam int unsigned NBEATS     = LINE_W / BEAT_W;
    localparam int unsigned BEAT_IDX_W = 2;
    localparam int unsigned OFFSET_W   = 6;
    localparam int unsigned SET_W      = 6;
    localparam int unsigned LADDR_W    = NPHYS - OFFSET_W;
    localparam int unsigned TAG_W      = NPHYS - OFFSET_W - SET_W;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        FILL_IDLE    = 2'd0,
        FILL_COLLECT = 2'd1,
        FILL_WRITE   = 2'd2,
        FILL_DONE    = 2'd3
    } fill_state_t;

    typedef struct packed {
        logic [LADDR_W-1:0]    line_addr;
        logic [BEAT_IDX_W-1:0] first;
    } fill_req_t;

endpackage

// File: rtl/dc1_fill.sv
// L1 data cache line-fill engine: collects four wrapped beats, forwards the critical one,
// then writes the assembled line and its tag into the dc1 arrays.
module dc1_fill
    import dc1_fill_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [LADDR_W-1:0]    req_addr,
    input  logic [BEAT_IDX_W-1:0] req_first,
    input  logic                  beat_valid,
    output logic                  beat_ready,
    input  logic [BEAT_W-1:0]     beat_data,
    input  logic                  beat_last,
    input  logic                  beat_err,
    output logic                  crit_valid,
    output logic [BEAT_W-1:0]     crit_data,
    output logic [BEAT_IDX_W-1:0] crit_idx,
    output logic                  wr_req,
    input  logic                  wr_gnt,
    output logic                  wen,
    output logic [SET_W-1:0]      waddr,
    output logic [LINE_W-1:0]     din,
    output logic [TAG_W-1:0]      tin,
    output logic                  done_valid,
    output logic                  done_err,
    output logic                  busy
);

    fill_state_t           state_q, state_d;
    fill_req_t             req_q;
    logic [BEAT_IDX_W-1:0] cnt_q, cnt_d;
    logic                  err_q, err_d;
    line_t                 line_q;
    logic                  req_fire;
    logic                  beat_fire;

    // Beat k of a wrapped burst lands in slot (first + k) mod NBEATS.
    function automatic logic [BEAT_IDX_W-1:0] slot_of(input logic [BEAT_IDX_W-1:0] first,
                                                      input logic [BEAT_IDX_W-1:0] k);
        return BEAT_IDX_W'(first + k);
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= FILL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        beat_ready = 1'b0;
        wr_req     = 1'b0;
        done_valid = 1'b0;
        done_err   = 1'b0;
        req_fire   = 1'b0;
        beat_fire  = 1'b0;
        case (state_q)
            FILL_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    req_fire = 1'b1;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    state_d  = FILL_COLLECT;
                end
            end
            FILL_COLLECT: begin
                beat_ready = 1'b1;
                if (beat_valid) begin
                    beat_fire = 1'b1;
                    cnt_d     = BEAT_IDX_W'(cnt_q + BEAT_IDX_W'(1));
                    if (beat_err) begin
                        err_d = 1'b1;
                    end
                    // A burst must end exactly on its fourth beat; either mismatch aborts the fill.
                    if (cnt_q == BEAT_IDX_W'(NBEATS - 1)) begin
                        if (!beat_last) begin
                            err_d = 1'b1;
                        end
                        state_d = (err_q || beat_err || !beat_last) ? FILL_DONE : FILL_WRITE;
                    end else if (beat_last) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = FILL_DONE;
                    end
                end
            end
            FILL_WRITE: begin
                wr_req = 1'b1;
                if (wr_gnt) begin
                    state_d = FILL_DONE;
                end
            end
            FILL_DONE: begin
                done_valid = 1'b1;
                done_err   = err_q;
                state_d    = FILL_IDLE;
            end
            default: begin
                state_d = FILL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_q  <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            line_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
            if (req_fire) begin
                req_q.line_addr <= req_addr;
                req_q.first     <= req_first;
            end
            if (beat_fire) begin
                line_q[int'(slot_of(req_q.first, cnt_q)) * BEAT_W +: BEAT_W] <= beat_data;
            end
        end
    end

    // Critical beat bypasses the line buffer so the load pipe can restart a cycle early.
    assign crit_valid = beat_fire && (cnt_q == '0);
    assign crit_data  = crit_valid ? beat_data : '0;
    assign crit_idx   = crit_valid ? req_q.first : '0;

    assign wen   = wr_req & wr_gnt;
    assign waddr = req_q.line_addr[SET_W-1:0];
    assign tin   = req_q.line_addr[LADDR_W-1:SET_W];
    assign din   = line_q;
    assign busy  = (state_q != FILL_IDLE);

endmodule

// File: tb/tb_dc1_fill.sv
// Directed bench for dc1_fill with a scoreboard of expected critical beats, line writes and completions.
module tb_dc1_fill;
    import dc1_fill_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  req_valid;
    logic                  req_ready;
    logic [LADDR_W-1:0]    req_addr;
    logic [BEAT_IDX_W-1:0] req_first;
    logic                  beat_valid;
    logic                  beat_ready;
    logic [BEAT_W-1:0]     beat_data;
    logic                  beat_last;
    logic                  beat_err;
    logic                  crit_valid;
    logic [BEAT_W-1:0]     crit_data;
    logic [BEAT_IDX_W-1:0] crit_idx;
    logic                  wr_req;
    logic                  wr_gnt;
    logic                  wen;
    logic [SET_W-1:0]      waddr;
    logic [LINE_W-1:0]     din;
    logic [TAG_W-1:0]      tin;
    logic                  done_valid;
    logic                  done_err;
    logic                  busy;

    dc1_fill dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_first(req_first),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_data(beat_data),
        .beat_last(beat_last), .beat_err(beat_err),
        .crit_valid(crit_valid), .crit_data(crit_data), .crit_idx(crit_idx),
        .wr_req(wr_req), .wr_gnt(wr_gnt), .wen(wen), .waddr(waddr), .din(din), .tin(tin),
        .done_valid(done_valid), .done_err(done_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BEAT_W-1:0]     data;
        logic [BEAT_IDX_W-1:0] idx;
    } crit_exp_t;

    typedef struct {
        logic [SET_W-1:0] waddr;
        line_t            din;
        logic [TAG_W-1:0] tin;
        int               cyc;
    } wr_exp_t;

    typedef struct {
        logic err;
        int   cyc;
    } done_exp_t;

    crit_exp_t crit_q[$];
    wr_exp_t   wr_q[$];
    done_exp_t done_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BEAT_W-1:0] rep(input logic [3:0] n);
        return {32{n}};
    endfunction

    // Output monitor: every crit/wen/done event must match the head of its queue.
    always @(negedge clk) begin
        crit_exp_t ce;
        wr_exp_t   we;
        done_exp_t de;
        if (crit_valid) begin
            chk("crit_expected", LINE_W'(crit_q.size() > 0), LINE_W'(1));
            if (crit_q.size() > 0) begin
                ce = crit_q.pop_front();
                chk("crit_data", LINE_W'(crit_data), LINE_W'(ce.data));
                chk("crit_idx", LINE_W'(crit_idx), LINE_W'(ce.idx));
            end
        end
        if (wen) begin
            chk("wen_expected", LINE_W'(wr_q.size() > 0), LINE_W'(1));
            if (wr_q.size() > 0) begin
                we = wr_q.pop_front();
                chk("waddr", LINE_W'(waddr), LINE_W'(we.waddr));
                chk("din", din, we.din);
                chk("tin", LINE_W'(tin), LINE_W'(we.tin));
                if (we.cyc >= 0) chk("wen_cycle", LINE_W'(cyc), LINE_W'(we.cyc));
            end
        end
        if (done_valid) begin
            chk("done_expected", LINE_W'(done_q.size() > 0), LINE_W'(1));
            if (done_q.size() > 0) begin
                de = done_q.pop_front();
                chk("done_err", LINE_W'(done_err), LINE_W'(de.err));
                chk("done_cycle", LINE_W'(cyc), LINE_W'(de.cyc));
            end
        end
    end

    // Waits (bounded) for an idle engine, then presents one request for exactly one edge.
    task automatic do_req(input logic [LADDR_W-1:0] addr, input logic [1:0] first, output int t);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", LINE_W'(req_ready), LINE_W'(1));
        req_valid = 1'b1;
        req_addr  = addr;
        req_first = first;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        t = cyc;
    endtask

    task automatic send_beat(input logic [BEAT_W-1:0] data, input logic last, input logic err);
        beat_valid = 1'b1;
        beat_data  = data;
        beat_last  = last;
        beat_err   = err;
        @(negedge clk);
        chk("beat_ready", LINE_W'(beat_ready), LINE_W'(1));
        @(posedge clk);
        #1;
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        beat_err   = 1'b0;
    endtask

    task automatic clean_fill(input logic [LADDR_W-1:0] addr, input logic [1:0] first,
                              input logic [BEAT_W-1:0] b0, input logic [BEAT_W-1:0] b1,
                              input logic [BEAT_W-1:0] b2, input logic [BEAT_W-1:0] b3,
                              input line_t exp_line);
        int t;
        do_req(addr, first, t);
        crit_q.push_back('{data: b0, idx: first});
        wr_q.push_back('{waddr: addr[SET_W-1:0], din: exp_line, tin: addr[LADDR_W-1:SET_W], cyc: t + 4});
        done_q.push_back('{err: 1'b0, cyc: t + 5});
        send_beat(b0, 1'b0, 1'b0);
        send_beat(b1, 1'b0, 1'b0);
        send_beat(b2, 1'b0, 1'b0);
        send_beat(b3, 1'b1, 1'b0);
    endtask

    initial begin
        int t;
        wr_exp_t we;
        logic [LADDR_W-1:0] a;
        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        req_first  = '0;
        beat_valid = 1'b0;
        beat_data  = '0;
        beat_last  = 1'b0;
        beat_err   = 1'b0;
        wr_gnt     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", LINE_W'(req_ready), LINE_W'(1));
        chk("rst_beat_ready", LINE_W'(beat_ready), LINE_W'(0));
        chk("rst_busy", LINE_W'(busy), LINE_W'(0));
        chk("rst_wr_req", LINE_W'(wr_req), LINE_W'(0));
        chk("rst_wen", LINE_W'(wen), LINE_W'(0));
        chk("rst_done", LINE_W'(done_valid), LINE_W'(0));
        chk("rst_waddr", LINE_W'(waddr), LINE_W'(0));
        chk("rst_tin", LINE_W'(tin), LINE_W'(0));

        // Normal fill, critical beat 0
        a = LADDR_W'(64'h1234_57C0 >> 6);
        do_req(a, 2'd0, t);
        crit_q.push_back('{data: rep(4'hA), idx: 2'd0});
        wr_q.push_back('{waddr: 6'h1F, din: {rep(4'hD), rep(4'hC), rep(4'hB), rep(4'hA)},
                         tin: TAG_W'(20'h12345), cyc: t + 4});
        done_q.push_back('{err: 1'b0, cyc: t + 5});
        send_beat(rep(4'hA), 1'b0, 1'b0);
        send_beat(rep(4'hB), 1'b0, 1'b0);
        send_beat(rep(4'hC), 1'b0, 1'b0);
        send_beat(rep(4'hD), 1'b1, 1'b0);

        // Wrapped fill, critical beat 2: P,Q,R,S land as {Q,P,S,R}
        clean_fill(49'h0_1234_5678_9ABC, 2'd2, rep(4'h1), rep(4'h2), rep(4'h3), rep(4'h4),
                   {rep(4'h2), rep(4'h1), rep(4'h4), rep(4'h3)});

        // Write-port contention: no grant for five cycles after the last beat
        a = 49'h1_F0F0_0000_1240;
        do_req(a, 2'd1, t);
        we = '{waddr: a[SET_W-1:0], din: {rep(4'h7), rep(4'h6), rep(4'h5), rep(4'h8)},
               tin: a[LADDR_W-1:SET_W], cyc: t + 9};
        crit_q.push_back('{data: rep(4'h5), idx: 2'd1});
        wr_q.push_back(we);
        done_q.push_back('{err: 1'b0, cyc: t + 10});
        send_beat(rep(4'h5), 1'b0, 1'b0);
        send_beat(rep(4'h6), 1'b0, 1'b0);
        send_beat(rep(4'h7), 1'b0, 1'b0);
        wr_gnt = 1'b0;
        send_beat(rep(4'h8), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_wr_req", LINE_W'(wr_req), LINE_W'(1));
            chk("stall_waddr", LINE_W'(waddr), LINE_W'(we.waddr));
            chk("stall_din", din, we.din);
            chk("stall_tin", LINE_W'(tin), LINE_W'(we.tin));
            @(posedge clk);
            #1;
        end
        wr_gnt = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_gnt_wr_req", LINE_W'(wr_req), LINE_W'(0));

        // Bus error on beat 1: all beats consumed, no write, errored completion
        do_req(49'h0_0000_0000_0055, 2'd3, t);
        crit_q.push_back('{data: rep(4'h9), idx: 2'd3});
        done_q.push_back('{err: 1'b1, cyc: t + 4});
        send_beat(rep(4'h9), 1'b0, 1'b0);
        send_beat(rep(4'hE), 1'b0, 1'b1);
        send_beat(rep(4'hF), 1'b0, 1'b0);
        send_beat(rep(4'h0), 1'b1, 1'b0);

        // Short burst: beat_last on beat 2
        do_req(49'h0_0000_0000_0033, 2'd1, t);
        crit_q.push_back('{data: rep(4'hC), idx: 2'd1});
        done_q.push_back('{err: 1'b1, cyc: t + 3});
        send_beat(rep(4'hC), 1'b0, 1'b0);
        send_beat(rep(4'hD), 1'b0, 1'b0);
        send_beat(rep(4'hE), 1'b1, 1'b0);
        @(negedge clk);
        chk("short_req_ready_done", LINE_W'(req_ready), LINE_W'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("short_req_ready_idle", LINE_W'(req_ready), LINE_W'(1));
        clean_fill(49'h0_ABCD_0000_0007, 2'd3, rep(4'h1), rep(4'h2), rep(4'h3), rep(4'h4),
                   {rep(4'h1), rep(4'h4), rep(4'h3), rep(4'h2)});

        // Fourth beat without beat_last: errored, extra beat refused
        do_req(49'h0_0000_0000_0011, 2'd0, t);
        crit_q.push_back('{data: rep(4'h6), idx: 2'd0});
        done_q.push_back('{err: 1'b1, cyc: t + 4});
        send_beat(rep(4'h6), 1'b0, 1'b0);
        send_beat(rep(4'h7), 1'b0, 1'b0);
        send_beat(rep(4'h8), 1'b0, 1'b0);
        send_beat(rep(4'h9), 1'b0, 1'b0);
        beat_valid = 1'b1;
        beat_data  = rep(4'hB);
        @(negedge clk);
        chk("extra_beat_done", LINE_W'(beat_ready), LINE_W'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("beat_in_idle", LINE_W'(beat_ready), LINE_W'(0));
        chk("idle_busy", LINE_W'(busy), LINE_W'(0));
        @(posedge clk);
        #1;
        beat_valid = 1'b0;

        // Reset mid-fill after two beats
        do_req(49'h0_5555_5555_5540, 2'd0, t);
        crit_q.push_back('{data: rep(4'hE), idx: 2'd0});
        send_beat(rep(4'hE), 1'b0, 1'b0);
        send_beat(rep(4'hE), 1'b0, 1'b0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_req_ready", LINE_W'(req_ready), LINE_W'(1));
        chk("midrst_busy", LINE_W'(busy), LINE_W'(0));
        clean_fill(49'h0_5555_5555_5540, 2'd2, rep(4'h3), rep(4'h5), rep(4'h7), rep(4'h9),
                   {rep(4'h5), rep(4'h3), rep(4'h9), rep(4'h7)});

        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("crit_q_empty", LINE_W'(crit_q.size()), LINE_W'(0));
        chk("wr_q_empty", LINE_W'(wr_q.size()), LINE_W'(0));
        chk("done_q_empty", LINE_W'(done_q.size()), LINE_W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
